fpga_audio_spi_slave: RTL and testbench
=======================================

Name: fpga_audio_spi_slave

Overview:
- SPI responder (slave) for the audio SoC. It is the far-end counterpart of the 8-bit SPI master peripheral: mode 0 (CPOL=0, CPHA=0), MSB first.
- Bus side: the same Avalon-style register slave used by the SPI master.
- Line side: SCLK, SS_n and MOSI are synchronized into clk. A shift FSM receives into an RX holding register and transmits from a TX holding register.

Parameters:
- DATABITS, 8, shift width. Only 8 is supported.
- SYNC_STAGES, 2, synchronizer depth on SCLK/SS_n/MOSI. Legal range 2..3.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  reset
- spi_select  in  1  register chip select
- mem_addr  in  3  register address
- read_n  in  1  read strobe, active low
- write_n  in  1  write strobe, active low
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  read data, registered
- irq  out  1  interrupt, registered
- SCLK  in  1  SPI clock from the master
- SS_n  in  1  slave select, active low
- MOSI  in  1  master-out data
- MISO  out  1  slave-out data
- MISO_oe  out  1  tristate enable for MISO; 1 while selected

Behaviour:
- Reset: reset reset_n, asynchronous, active-low; clock clk. All outputs reset to 0 (MISO=0, MISO_oe=0, irq=0, data_to_cpu=0).
  - Synchronizer flops reset to SCLK=0, SS_n=1, MOSI=0.
  - FSM resets to IDLE.
- Register map:
  - 0: RX data, read-only.
  - 1: TX data, write-only.
  - 2: status; read, or write any value to clear.
  - 3: control (irq enables), read/write.
  - Other addresses read 0.
- Status bits: [8] E=TOE|ROE, [7] RRDY, [6] TRDY, [5] TMT, [4] TOE, [3] ROE, [2] UNDR, [1] ABT, [0] SEL (synchronized ~SS_n).
  - TRDY = ~tx_primed.
  - TMT = ~tx_primed & (state==IDLE).
- Control bits: [8]..[1] are irq enables matching the status bits 1:1; reset 0.
- irq: registered OR of (status & enable); 1-cycle latency.
- Bus timing:
  - Read and write are two-cycle events, as on the master: a one-shot strobe, then the action on the second cycle.
  - data_to_cpu is valid on the second cycle.
  - Reading addr 0 clears RRDY.
- TX write:
  - If TRDY=1: load tx_hold[7:0] and set tx_primed.
  - If TRDY=0: set TOE and drop the data.
- Edge detect: rise/fall pulses are taken from the last two synchronized SCLK samples. Total MOSI/SCLK-to-action latency is SYNC_STAGES+1 clk.
- Timing requirement: SCLK half-period must be at least 6 clk. The master's 10-clk half-period satisfies this.
- FSM states:
  - IDLE: MISO_oe=0, bitcnt=0. On SS_n falling (synchronized), go to LOAD.
  - LOAD (1 cycle):
    - If tx_primed: shift_reg <= tx_hold and clear tx_primed.
    - Else: shift_reg <= 8'h00 and set UNDR.
    - MISO = shift_reg[7]. Go to SHIFT.
  - SHIFT:
    - On rise: rx_shift <= {rx_shift[6:0], MOSI_sync} and bitcnt++.
    - On fall, when bitcnt!=0 and bitcnt!=8: shift_reg <= shift_reg<<1.
    - When bitcnt reaches 8: go to DONE.
  - DONE (1 cycle):
    - rx_hold <= rx_shift and RRDY <= 1; if RRDY was already 1, set ROE.
    - bitcnt <= 0. Go to LOAD, which prepares the next byte of a continuous burst.
    - The reload completes before the master's next rising edge.
- MISO_oe = 1 in LOAD/SHIFT/DONE. MISO holds shift_reg[7].
- SS_n rises in any non-IDLE state: go to IDLE.
  - If bitcnt was 1..7, the partial byte is discarded: set ABT, no RRDY.
  - A word already loaded but not fully sent is lost; tx_primed is not restored.
- Simultaneous events, all resolved set-over-clear:
  - Status write in the same cycle as DONE: clear, then set; RRDY=1 and ROE follows the pre-clear RRDY.
  - RX read in the same cycle as DONE: the read returns the old rx_hold and RRDY stays 1.
  - TX write in the same cycle as LOAD with tx_primed=0: LOAD sends 0x00 with UNDR set, and the write primes tx_hold for the next byte.

Decomposition:
- Shared package fpga_audio_spi_pkg: register address constants, status/control bit indices, and the FSM state enum (IDLE, LOAD, SHIFT, DONE). The SPI master's regs reuse the same address/bit constants.
- One sub-module, spi_sync_edge: a SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, instantiated for SCLK and SS_n. MOSI uses the synchronizer only.

Test Plan:
- Reset, then read status -> 0x0060 (TRDY=1, TMT=1). MISO_oe=0, irq=0.
- Write TX=0xA5; master sends 0x3C, half-period 10 clk -> master receives 0xA5; status RRDY=1, TRDY=1; RX read=0x003C; RRDY then 0.
- Two-byte burst with SS_n held low: TX 0x11, then 0x22 written during byte 1 -> MISO sequence 0x11, 0x22. Neither RX byte is read -> ROE=1 and E=1; RX read returns the second byte.
- Select with no TX primed -> MISO carries 0x00 and UNDR=1. Control=0x0004 -> irq rises 1 clk after UNDR sets.
- SS_n raised after 3 SCLK rising edges -> ABT=1, RRDY=0, FSM in IDLE, MISO_oe=0. Status write clears ABT/UNDR/ROE/TOE.
- Write TX twice while not transmitting -> TOE=1 and the first value is kept. Assert reset_n low mid-byte -> all status 0 except TRDY/TMT; MISO_oe=0 immediately.

Source files
------------

// File: rtl/fpga_audio_spi_pkg.sv
// Shared register map, status/control bit positions and shift-FSM states for
// the audio SPI master and slave peripherals.
package fpga_audio_spi_pkg;

   localparam logic [2:0] ADDR_RX      = 3'd0;
   localparam logic [2:0] ADDR_TX      = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;

   localparam int ST_E    = 8;
   localparam int ST_RRDY = 7;
   localparam int ST_TRDY = 6;
   localparam int ST_TMT  = 5;
   localparam int ST_TOE  = 4;
   localparam int ST_ROE  = 3;
   localparam int ST_UNDR = 2;
   localparam int ST_ABT  = 1;
   localparam int ST_SEL  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_state_t;

endpackage

// File: rtl/fpga_audio_spi_slave_sync.sv
// Multi-stage synchronizer for one SPI line into clk, with single-cycle
// rise/fall pulses taken from the last two synchronized samples.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= {SYNC_STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], async_in};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign sync_out = chain[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev;
   assign fall     = ~sync_out & prev;

endmodule

// File: rtl/fpga_audio_spi_slave.sv
// SPI mode-0 responder with an Avalon-style register interface: receives into
// an RX holding register and transmits from a TX holding register.
//
// state | meaning
// IDLE  | deselected, MISO tristated, bit counter cleared
// LOAD  | one cycle: move tx_hold (or 0x00 on underrun) into the shifter
// SHIFT | sample MOSI on SCLK rise, advance MISO on SCLK fall
// DONE  | one cycle: publish received byte, then reload for a burst
module fpga_audio_spi_slave
   import fpga_audio_spi_pkg::*;
#(
   parameter int DATABITS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   output logic        irq,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe
);

   localparam logic [3:0] BITS_LAST = 4'(DATABITS);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic ss_sync, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_chain;
   logic mosi_sync;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .async_in(SCLK),
      .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk(clk), .reset_n(reset_n), .async_in(SS_n),
      .sync_out(ss_sync), .rise(ss_rise), .fall(ss_fall)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mosi_chain <= '0;
      else          mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
   end
   assign mosi_sync = mosi_chain[SYNC_STAGES-1];

   // Bus: first cycle of a strobe registers a one-shot, second cycle acts.
   logic       rd_act, wr_act, rd_act_q, wr_act_q, rd_stb, wr_stb;
   logic [2:0] addr_q;
   logic [8:0] wdata_q;

   assign rd_act = spi_select & ~read_n;
   assign wr_act = spi_select & ~write_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_act_q <= 1'b0;
         wr_act_q <= 1'b0;
         rd_stb   <= 1'b0;
         wr_stb   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         rd_act_q <= rd_act;
         wr_act_q <= wr_act;
         rd_stb   <= rd_act & ~rd_act_q;
         wr_stb   <= wr_act & ~wr_act_q;
         if ((rd_act & ~rd_act_q) | (wr_act & ~wr_act_q)) addr_q <= mem_addr;
         if (wr_act & ~wr_act_q) wdata_q <= data_from_cpu[8:0];
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, data_from_cpu[15:9], sclk_sync};

   logic rd_rx, wr_tx, wr_status, wr_ctrl;
   assign rd_rx     = rd_stb && (addr_q == ADDR_RX);
   assign wr_tx     = wr_stb && (addr_q == ADDR_TX);
   assign wr_status = wr_stb && (addr_q == ADDR_STATUS);
   assign wr_ctrl   = wr_stb && (addr_q == ADDR_CONTROL);

   spi_state_t state, state_nxt;
   logic [3:0]          bitcnt;
   logic [DATABITS-1:0] shift_reg, rx_shift, rx_hold, tx_hold;
   logic                tx_primed, rrdy, roe, toe, undr, abt;
   logic [8:1]          ctrl;
   logic [8:0]          status;

   always_comb begin
      status          = '0;
      status[ST_E]    = toe | roe;
      status[ST_RRDY] = rrdy;
      status[ST_TRDY] = ~tx_primed;
      status[ST_TMT]  = ~tx_primed & (state == IDLE);
      status[ST_TOE]  = toe;
      status[ST_ROE]  = roe;
      status[ST_UNDR] = undr;
      status[ST_ABT]  = abt;
      status[ST_SEL]  = ~ss_sync;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ss_fall) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (bitcnt == BITS_LAST) state_nxt = DONE;
         DONE:    state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && ss_rise) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitcnt    <= '0;
         shift_reg <= '0;
         rx_shift  <= '0;
         rx_hold   <= '0;
         tx_hold   <= '0;
         tx_primed <= 1'b0;
         rrdy      <= 1'b0;
         roe       <= 1'b0;
         toe       <= 1'b0;
         undr      <= 1'b0;
         abt       <= 1'b0;
         ctrl      <= '0;
      end else begin
         // Clears come first so any set in the same cycle wins.
         if (wr_status) begin
            rrdy <= 1'b0;
            roe  <= 1'b0;
            toe  <= 1'b0;
            undr <= 1'b0;
            abt  <= 1'b0;
         end
         if (rd_rx)   rrdy <= 1'b0;
         if (wr_ctrl) ctrl <= wdata_q[8:1];
         if (wr_tx) begin
            if (!tx_primed) begin
               tx_hold   <= wdata_q[DATABITS-1:0];
               tx_primed <= 1'b1;
            end else begin
               toe <= 1'b1;
            end
         end

         if (state != IDLE && ss_rise) begin
            bitcnt <= '0;
            if (bitcnt != 4'd0 && bitcnt < BITS_LAST) abt <= 1'b1;
         end else begin
            case (state)
               IDLE: bitcnt <= '0;
               LOAD: begin
                  if (tx_primed) begin
                     shift_reg <= tx_hold;
                     tx_primed <= 1'b0;
                  end else begin
                     shift_reg <= '0;
                     undr      <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (sclk_rise && bitcnt < BITS_LAST) begin
                     rx_shift <= {rx_shift[DATABITS-2:0], mosi_sync};
                     bitcnt   <= bitcnt + 4'd1;
                  end else if (sclk_fall && bitcnt != 4'd0 && bitcnt != BITS_LAST) begin
                     shift_reg <= {shift_reg[DATABITS-2:0], 1'b0};
                  end
               end
               DONE: begin
                  rx_hold <= rx_shift;
                  rrdy    <= 1'b1;
                  if (rrdy) roe <= 1'b1;
                  bitcnt  <= '0;
               end
               default: bitcnt <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_to_cpu <= '0;
         irq         <= 1'b0;
      end else begin
         irq <= |(status[8:1] & ctrl);
         if (rd_stb) begin
            case (addr_q)
               ADDR_RX:      data_to_cpu <= 16'(rx_hold);
               ADDR_STATUS:  data_to_cpu <= 16'(status);
               ADDR_CONTROL: data_to_cpu <= 16'({ctrl, 1'b0});
               default:      data_to_cpu <= '0;
            endcase
         end
      end
   end

   assign MISO    = shift_reg[DATABITS-1];
   assign MISO_oe = (state != IDLE);

endmodule

// File: tb/tb_fpga_audio_spi_slave.sv
// Directed bench for fpga_audio_spi_slave: a behavioural mode-0 SPI master
// (10-clk half period) and register-bus tasks against hand-computed values.
module tb_fpga_audio_spi_slave;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_select = 1'b0;
   logic [2:0]  mem_addr = '0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [15:0] data_from_cpu = '0;
   logic [15:0] data_to_cpu;
   logic        irq;
   logic        SCLK = 1'b0;
   logic        SS_n = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic        MISO_oe;

   int total = 0;
   int bad = 0;

   localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_CTL = 3'd3;

   fpga_audio_spi_slave dut (
      .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
      .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
      .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
      .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      d = data_to_cpu;
      spi_select = 1'b0; read_n = 1'b1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; mem_addr = a; write_n = 1'b0; data_from_cpu = d;
      @(negedge clk);
      @(negedge clk);
      spi_select = 1'b0; write_n = 1'b1;
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         MOSI = mo[i];
         wait_clk(10);
         mi[i] = MISO;
         SCLK = 1'b1;
         wait_clk(10);
         SCLK = 1'b0;
      end
   endtask

   task automatic deselect();
      wait_clk(10);
      SS_n = 1'b1;
      wait_clk(10);
   endtask

   logic [15:0] rd;
   logic [7:0]  m1, m2;

   initial begin
      wait_clk(4);
      chk("reset_data_to_cpu", data_to_cpu, 16'h0000);
      chk("reset_oe", 16'(MISO_oe), 16'h0000);
      chk("reset_irq", 16'(irq), 16'h0000);
      reset_n = 1'b1;
      wait_clk(2);
      bus_read(A_ST, rd);
      chk("reset_status", rd, 16'h0060);

      // single byte
      bus_write(A_TX, 16'h00A5);
      bus_read(A_ST, rd);
      chk("primed_status", rd, 16'h0000);
      SS_n = 1'b0;
      spi_bits(8'h3C, 8, m1);
      deselect();
      chk("single_miso", 16'(m1), 16'h00A5);
      bus_read(A_ST, rd);
      chk("single_status", rd & 16'h01F8, 16'h00E0);
      bus_read(A_RX, rd);
      chk("single_rx", rd, 16'h003C);
      bus_read(A_ST, rd);
      chk("rrdy_cleared", rd & 16'h0080, 16'h0000);

      // two-byte burst, second TX written during byte 1
      bus_write(A_ST, 16'h0000);
      bus_write(A_TX, 16'h0011);
      SS_n = 1'b0;
      fork
         begin
            spi_bits(8'h5A, 8, m1);
            spi_bits(8'hC3, 8, m2);
         end
         begin
            wait_clk(30);
            bus_write(A_TX, 16'h0022);
         end
      join
      deselect();
      chk("burst_miso1", 16'(m1), 16'h0011);
      chk("burst_miso2", 16'(m2), 16'h0022);
      bus_read(A_ST, rd);
      chk("burst_status", rd & 16'h01F8, 16'h01E8);
      bus_read(A_RX, rd);
      chk("burst_rx", rd, 16'h00C3);

      // underrun with irq enabled on UNDR
      bus_write(A_ST, 16'h0000);
      bus_write(A_CTL, 16'h0004);
      bus_read(A_CTL, rd);
      chk("ctrl_readback", rd, 16'h0004);
      chk("irq_before", 16'(irq), 16'h0000);
      SS_n = 1'b0;
      wait_clk(4);
      chk("irq_at_undr", 16'(irq), 16'h0000);
      wait_clk(1);
      chk("irq_after_undr", 16'(irq), 16'h0001);
      chk("oe_selected", 16'(MISO_oe), 16'h0001);
      spi_bits(8'hFF, 8, m1);
      deselect();
      chk("undr_miso", 16'(m1), 16'h0000);
      bus_read(A_ST, rd);
      chk("undr_bit", rd & 16'h0004, 16'h0004);

      // abort after 3 bits
      bus_write(A_ST, 16'h0000);
      bus_write(A_CTL, 16'h0000);
      SS_n = 1'b0;
      spi_bits(8'hE0, 3, m1);
      deselect();
      bus_read(A_ST, rd);
      chk("abort_status", rd, 16'h0066);
      chk("abort_oe", 16'(MISO_oe), 16'h0000);
      bus_write(A_ST, 16'h0000);
      bus_read(A_ST, rd);
      chk("status_cleared", rd, 16'h0060);

      // TX overrun keeps first value
      bus_write(A_TX, 16'h0077);
      bus_write(A_TX, 16'h0099);
      bus_read(A_ST, rd);
      chk("toe_status", rd, 16'h0110);
      SS_n = 1'b0;
      spi_bits(8'h00, 8, m1);
      deselect();
      chk("toe_miso", 16'(m1), 16'h0077);

      // reset mid-byte
      bus_write(A_TX, 16'h0055);
      SS_n = 1'b0;
      spi_bits(8'hAA, 2, m1);
      MOSI = 1'b1;
      wait_clk(4);
      chk("oe_before_reset", 16'(MISO_oe), 16'h0001);
      #3 reset_n = 1'b0;
      #1;
      chk("reset_oe_async", 16'(MISO_oe), 16'h0000);
      chk("reset_irq_async", 16'(irq), 16'h0000);
      SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(5);
      bus_read(A_ST, rd);
      chk("post_reset_status", rd, 16'h0060);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
